// File: rtl/branch_seq_pkg.sv
// Shared CPU definitions for the branch sequencer: opcode, FSM encoding, IR field positions.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package branch_seq_pkg;

    // Default IR[31:27] value for a conditional branch
    localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

    // Instruction register field positions
    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_C_HI   = 18;
    localparam int IR_C_LO   = 0;
    localparam int OFF_W     = IR_C_HI - IR_C_LO + 1;

    // Branch sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FFRST  = 3'd1,
        ST_EVAL   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_TARGET = 3'd4,
        ST_DONE   = 3'd5
    } br_state_t;

    // Sign-extend the 19-bit branch displacement to a full address
    function automatic logic [31:0] sext_off(input logic [OFF_W-1:0] off);
        return {{(32-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/branch_seq_target_add.sv
// Branch target adder: PC plus sign-extended 19-bit displacement, modulo 2^32.
// Latency: combinational; the caller registers the result.
// Backpressure: none; result is valid whenever its inputs are.
module br_target_add
    import branch_seq_pkg::*;
(
    input  logic [31:0]      pc_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [31:0]      target_o
);

    // Carry out of bit 31 is dropped: wrap-around is silent
    assign target_o = pc_i + sext_off(off_i);

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch sequencer: clears the CON flip-flop, evaluates Ra, then loads the target PC.
// Latency: start at edge N -> pc_load in cycle N+4 and done in N+5 if taken, done in N+4 if not.
// Backpressure: start is ignored while busy; a bad opcode in IDLE pulses err for one cycle.
module branch_seq
    import branch_seq_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic [31:0] PC,
    input  logic        CON_out,
    output logic [3:0]  ra_sel,
    output logic        R_out,
    output logic        CON_in,
    output logic        con_FF_Reset,
    output logic        pc_load,
    output logic [31:0] pc_next,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        err
);

    br_state_t        state_q;
    logic [3:0]       ra_q;
    logic [OFF_W-1:0] off_q;
    logic [31:0]      pc_q;
    logic [31:0]      pc_next_q;
    logic [3:0]       ra_sel_q;
    logic             r_out_q;
    logic             con_in_q;
    logic             con_ff_reset_q;
    logic             pc_load_q;
    logic             busy_q;
    logic             done_q;
    logic             taken_q;
    logic             err_q;
    logic [31:0]      target_sum;
    logic             start_ok;

    // Condition code bits are consumed by the external CON logic, not here
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[22:19];

    assign start_ok = (IR[IR_OPC_HI:IR_OPC_LO] == BR_OPCODE);

    br_target_add u_target_add (
        .pc_i     (pc_q),
        .off_i    (off_q),
        .target_o (target_sum)
    );

    // Sequencer FSM; every output is registered from the transition taken at this edge
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q        <= ST_IDLE;
            ra_q           <= '0;
            off_q          <= '0;
            pc_q           <= '0;
            pc_next_q      <= '0;
            ra_sel_q       <= '0;
            r_out_q        <= 1'b0;
            con_in_q       <= 1'b0;
            con_ff_reset_q <= 1'b0;
            pc_load_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            taken_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            ra_sel_q       <= '0;
            r_out_q        <= 1'b0;
            con_in_q       <= 1'b0;
            con_ff_reset_q <= 1'b0;
            pc_load_q      <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        if (start_ok) begin
                            ra_q           <= IR[IR_RA_HI:IR_RA_LO];
                            off_q          <= IR[IR_C_HI:IR_C_LO];
                            pc_q           <= PC;
                            con_ff_reset_q <= 1'b1;
                            busy_q         <= 1'b1;
                            state_q        <= ST_FFRST;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_FFRST: begin
                    ra_sel_q <= ra_q;
                    r_out_q  <= 1'b1;
                    con_in_q <= 1'b1;
                    state_q  <= ST_EVAL;
                end
                ST_EVAL: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (CON_out) begin
                        taken_q   <= 1'b1;
                        pc_next_q <= target_sum;
                        pc_load_q <= 1'b1;
                        state_q   <= ST_TARGET;
                    end else begin
                        taken_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_TARGET: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ra_sel       = ra_sel_q;
    assign R_out        = r_out_q;
    assign CON_in       = con_in_q;
    assign con_FF_Reset = con_ff_reset_q;
    assign pc_load      = pc_load_q;
    assign pc_next      = pc_next_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign taken        = taken_q;
    assign err          = err_q;

endmodule
